// File: rtl/grid_gen_pkg.sv
// Shared types, saturation limits and the quarter-wave table generator for grid_voltage_gen.
package grid_gen_pkg;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quadrant_e;

    // pi scaled by 2^30, the fixed-point format used by the table generator
    localparam longint PI_Q30 = 64'sd3373259426;

    function automatic int max_pos(input int dw);
        return (32'sd1 <<< (dw - 1)) - 32'sd1;
    endfunction

    function automatic int max_neg(input int dw);
        return -max_pos(dw);
    endfunction

    // round(sin((k+0.5)*pi/(2N)) * max_pos), Taylor series to x^13 in Q30 integers
    function automatic int sin_lut_entry(input int k, input int addr_w, input int dw);
        longint x;
        longint x2;
        longint term;
        longint acc;
        x    = (longint'(2 * k + 1) * PI_Q30) / (64'sd4 <<< addr_w);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int n = 1; n <= 6; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return int'((acc * longint'(max_pos(dw)) + (64'sd1 <<< 29)) >>> 30);
    endfunction

endpackage

// File: rtl/grid_voltage_gen_if.sv
// AXI-Stream sample channel of grid_voltage_gen; width follows the lane count.
interface grid_voltage_gen_if #(
    parameter int TDATA_WIDTH = 12
);
    logic [TDATA_WIDTH-1:0] TDATA;
    logic                   TVALID;
    logic                   TREADY;
    logic                   TLAST;

    modport master (output TDATA, output TVALID, output TLAST, input TREADY);
    modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine ROM with synchronous read; COSINE_OUT_EN adds a second read port.
module sine_quarter_lut
    import grid_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic [ADDR_WIDTH-1:0] addr_a_i,
    output logic [DATA_WIDTH-1:0] data_a_o
`ifdef COSINE_OUT_EN
    ,
    input  logic [ADDR_WIDTH-1:0] addr_b_i,
    output logic [DATA_WIDTH-1:0] data_b_o
`endif
);
    localparam int N = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rom_s [N];
    logic [DATA_WIDTH-1:0] data_a_q;

    for (genvar k = 0; k < N; k++) begin : g_rom
        localparam logic [DATA_WIDTH-1:0] ENTRY = DATA_WIDTH'(sin_lut_entry(k, ADDR_WIDTH, DATA_WIDTH));
        assign rom_s[k] = ENTRY;
    end

    // Registered read, port A.
    always_ff @(posedge clk_i) begin
        data_a_q <= rom_s[addr_a_i];
    end
    assign data_a_o = data_a_q;

`ifdef COSINE_OUT_EN
    logic [DATA_WIDTH-1:0] data_b_q;

    // Registered read, port B.
    always_ff @(posedge clk_i) begin
        data_b_q <= rom_s[addr_b_i];
    end
    assign data_b_o = data_b_q;
`endif

endmodule

// File: rtl/grid_voltage_gen.sv
// Synthetic grid-voltage source: phase accumulator, quarter-wave sine, gain, AXI-Stream out.
// Define COSINE_OUT_EN to add a cosine lane packed above the sine lane.
module grid_voltage_gen
    import grid_gen_pkg::*;
#(
    parameter int DATA_WIDTH     = 12,
    parameter int PHASE_WIDTH    = 32,
    parameter int LUT_ADDR_WIDTH = 8,
    parameter int TICK_DIV       = 1000
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Enable,
    input  logic [PHASE_WIDTH-1:0] PhaseInc,
    input  logic [DATA_WIDTH-1:0]  Amplitude,
    grid_voltage_gen_if.master     M_AXIS,
    output logic                   Overrun
);
`ifdef COSINE_OUT_EN
    localparam int LANES = 2;
`else
    localparam int LANES = 1;
`endif
    localparam int DW2   = 2 * DATA_WIDTH;
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [DW2-1:0]        ROUND_BIAS = DW2'(1) << (DATA_WIDTH - 2);
    localparam logic [DW2-1:0]        SAT_WIDE   = DW2'(max_pos(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] SAT_MAG    = DATA_WIDTH'(max_pos(DATA_WIDTH));

    logic [CNT_W-1:0]       tick_cnt_q, tick_cnt_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d, phase_sum_s;
    logic                   phase_carry_s, tick_s;

    logic                                   s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [DATA_WIDTH-1:0]                  s1_amp_q, s1_amp_d;
    logic [LANES-1:0][LUT_ADDR_WIDTH-1:0]   s1_addr_q, s1_addr_d;
    logic [LANES-1:0]                       s1_neg_q, s1_neg_d;
    logic                                   s2_valid_q, s2_last_q;
    logic [DATA_WIDTH-1:0]                  s2_amp_q;
    logic [LANES-1:0]                       s2_neg_q;
    logic [LANES-1:0][DATA_WIDTH-1:0]       lut_s;
    logic [LANES*DATA_WIDTH-1:0]            sample_s;

    logic [LANES*DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic tvalid_q, tvalid_d, tlast_q, tlast_d, overrun_q, overrun_d;

    assign tick_s = Enable && (tick_cnt_q == CNT_LAST);
    assign {phase_carry_s, phase_sum_s} = {1'b0, phase_q} + {1'b0, PhaseInc};

    sine_quarter_lut #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (LUT_ADDR_WIDTH)
    ) u_lut (
        .clk_i    (Clk),
        .addr_a_i (s1_addr_q[0]),
        .data_a_o (lut_s[0])
`ifdef COSINE_OUT_EN
        ,
        .addr_b_i (s1_addr_q[1]),
        .data_b_o (lut_s[1])
`endif
    );

    // Sample-rate divider and phase accumulator.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        phase_d    = phase_q;
        if (!Enable) begin
            tick_cnt_d = tick_cnt_q;
        end else if (tick_s) begin
            tick_cnt_d = {CNT_W{1'b0}};
            phase_d    = phase_sum_s;
        end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end
    end

    // S1: quadrant fold into a LUT address plus sign, per lane.
    always_comb begin
        quadrant_e quad;
        quad       = QUAD_0;
        s1_valid_d = tick_s;
        s1_last_d  = s1_last_q;
        s1_amp_d   = s1_amp_q;
        s1_addr_d  = s1_addr_q;
        s1_neg_d   = s1_neg_q;
        if (tick_s) begin
            s1_last_d = phase_carry_s;
            s1_amp_d  = Amplitude;
            for (int l = 0; l < LANES; l++) begin
                // the cosine lane is a quarter turn ahead: only the quadrant changes
                quad = quadrant_e'(phase_q[PHASE_WIDTH-1 -: 2] + 2'(l));
                case (quad)
                    QUAD_0:  begin s1_addr_d[l] =  phase_q[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH]; s1_neg_d[l] = 1'b0; end
                    QUAD_1:  begin s1_addr_d[l] = ~phase_q[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH]; s1_neg_d[l] = 1'b0; end
                    QUAD_2:  begin s1_addr_d[l] =  phase_q[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH]; s1_neg_d[l] = 1'b1; end
                    QUAD_3:  begin s1_addr_d[l] = ~phase_q[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH]; s1_neg_d[l] = 1'b1; end
                    default: begin s1_addr_d[l] =  phase_q[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH]; s1_neg_d[l] = 1'b0; end
                endcase
            end
        end else begin
            s1_valid_d = 1'b0;
        end
    end

    // S3: gain, round half-up, saturate, apply sign; then the AXIS output register.
    always_comb begin
        logic [DW2-1:0]        prod;
        logic [DW2-1:0]        rnd;
        logic [DATA_WIDTH-1:0] mag;
        prod      = {DW2{1'b0}};
        rnd       = {DW2{1'b0}};
        mag       = {DATA_WIDTH{1'b0}};
        sample_s  = {(LANES*DATA_WIDTH){1'b0}};
        tdata_d   = tdata_q;
        tlast_d   = tlast_q;
        tvalid_d  = tvalid_q;
        overrun_d = overrun_q;
        for (int l = 0; l < LANES; l++) begin
            prod = DW2'(lut_s[l]) * DW2'(s2_amp_q);
            rnd  = (prod + ROUND_BIAS) >> (DATA_WIDTH - 1);
            if (rnd > SAT_WIDE) begin
                mag = SAT_MAG;
            end else begin
                mag = rnd[DATA_WIDTH-1:0];
            end
            if (s2_neg_q[l]) begin
                sample_s[l*DATA_WIDTH +: DATA_WIDTH] = -mag;
            end else begin
                sample_s[l*DATA_WIDTH +: DATA_WIDTH] = mag;
            end
        end
        if (s2_valid_q && (!tvalid_q || M_AXIS.TREADY)) begin
            tvalid_d = 1'b1;
            tdata_d  = sample_s;
            tlast_d  = s2_last_q;
        end else if (s2_valid_q) begin
            // consumer stalled: keep the held sample, lose the new one, time keeps running
            overrun_d = 1'b1;
        end else if (M_AXIS.TREADY) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tick_cnt_q <= {CNT_W{1'b0}};
            phase_q    <= {PHASE_WIDTH{1'b0}};
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_amp_q   <= {DATA_WIDTH{1'b0}};
            s1_addr_q  <= '0;
            s1_neg_q   <= {LANES{1'b0}};
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_amp_q   <= {DATA_WIDTH{1'b0}};
            s2_neg_q   <= {LANES{1'b0}};
            tdata_q    <= {(LANES*DATA_WIDTH){1'b0}};
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            phase_q    <= phase_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_amp_q   <= s1_amp_d;
            s1_addr_q  <= s1_addr_d;
            s1_neg_q   <= s1_neg_d;
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s2_amp_q   <= s1_amp_q;
            s2_neg_q   <= s1_neg_q;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            overrun_q  <= overrun_d;
        end
    end

    assign M_AXIS.TDATA  = tdata_q;
    assign M_AXIS.TVALID = tvalid_q;
    assign M_AXIS.TLAST  = tlast_q;
    assign Overrun       = overrun_q;

endmodule

// File: tb/tb_grid_voltage_gen.sv
// Directed bench for grid_voltage_gen with TICK_DIV=4; COSINE_OUT_EN also checks the cosine lane.
module tb_grid_voltage_gen;
    localparam int DW = 12;
`ifdef COSINE_OUT_EN
    localparam int TW = 2 * DW;
`else
    localparam int TW = DW;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Enable;
    logic [31:0] PhaseInc;
    logic [11:0] Amplitude;
    logic        Overrun;
    logic        tready;
    int          total = 0;
    int          bad = 0;

    grid_voltage_gen_if #(.TDATA_WIDTH(TW)) axis ();
    assign axis.TREADY = tready;

    logic signed [DW-1:0] sin_v;
    assign sin_v = axis.TDATA[DW-1:0];
`ifdef COSINE_OUT_EN
    logic signed [DW-1:0] cos_v;
    assign cos_v = axis.TDATA[2*DW-1:DW];
`endif

    grid_voltage_gen #(
        .DATA_WIDTH     (DW),
        .PHASE_WIDTH    (32),
        .LUT_ADDR_WIDTH (8),
        .TICK_DIV       (4)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Enable    (Enable),
        .PhaseInc  (PhaseInc),
        .Amplitude (Amplitude),
        .M_AXIS    (axis.master),
        .Overrun   (Overrun)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step(2);
        Reset = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!axis.TVALID && n < 64) begin
            step(1);
            n++;
        end
        check_val({tag, "_valid"}, 32'(axis.TVALID), 32'sd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lasts;
        int last_idx;
        int nvalid;
        logic signed [31:0] v [4];
        logic               l [4];
        logic signed [31:0] held;

        Reset = 1'b1; Enable = 1'b0; PhaseInc = 32'd0; Amplitude = 12'd0; tready = 1'b0;
        step(3);
        check_val("rst_tvalid", 32'(axis.TVALID), 32'sd0);
        check_val("rst_tdata", 32'(axis.TDATA), 32'sd0);
        check_val("rst_tlast", 32'(axis.TLAST), 32'sd0);
        check_val("rst_overrun", 32'(Overrun), 32'sd0);

        // Full period at 256 samples, unity gain
        PhaseInc = 32'h0100_0000; Amplitude = 12'd2048; tready = 1'b1; Enable = 1'b1;
        Reset = 1'b0;
        lasts = 0; last_idx = -1;
        for (int i = 0; i < 256; i++) begin
            wait_valid("t1");
            case (i)
                0:   check_val("t1_s0", sin_v, 32'sd6);
                64:  check_val("t1_s64", sin_v, 32'sd2047);
                128: check_val("t1_s128", sin_v, -32'sd6);
                192: check_val("t1_s192", sin_v, -32'sd2047);
                default: ;
            endcase
`ifdef COSINE_OUT_EN
            case (i)
                0:   check_val("t6_cos0", cos_v, 32'sd2047);
                64:  check_val("t6_cos64", cos_v, -32'sd6);
                128: check_val("t6_cos128", cos_v, -32'sd2047);
                192: check_val("t6_cos192", cos_v, 32'sd6);
                default: ;
            endcase
`endif
            if (axis.TLAST) begin
                lasts++;
                last_idx = i;
            end
            step(1);
        end
        check_val("t1_tlast_count", lasts, 32'sd1);
        check_val("t1_tlast_index", last_idx, 32'sd255);
        check_val("t1_overrun", 32'(Overrun), 32'sd0);

        // Gain saturation and rounding at the peak
        PhaseInc = 32'h4000_0000; Amplitude = 12'd4095;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_valid("t2a");
            v[i] = sin_v;
            l[i] = axis.TLAST;
            step(1);
        end
        check_val("t2_sat_s0", v[0], 32'sd12);
        check_val("t2_sat_peak", v[1], 32'sd2047);
        check_val("t2_sat_s2", v[2], -32'sd12);
        check_val("t2_sat_trough", v[3], -32'sd2047);
        check_val("t2_last0", 32'(l[0]), 32'sd0);
        check_val("t2_last3", 32'(l[3]), 32'sd1);
        Amplitude = 12'd1024;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wait_valid("t2b");
            v[i] = sin_v;
            step(1);
        end
        check_val("t2_half_s0", v[0], 32'sd3);
        check_val("t2_half_peak", v[1], 32'sd1024);
        check_val("t2_half_s2", v[2], -32'sd3);

        // Consumer stall across 10 ticks
        Amplitude = 12'd2048; PhaseInc = 32'h4000_0000; tready = 1'b0;
        do_reset();
        wait_valid("t3");
        check_val("t3_first", sin_v, 32'sd6);
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (k % 8 == 7) begin
                check_val("t3_hold_data", sin_v, 32'sd6);
                check_val("t3_hold_last", 32'(axis.TLAST), 32'sd0);
                check_val("t3_hold_valid", 32'(axis.TVALID), 32'sd1);
            end
        end
        check_val("t3_overrun", 32'(Overrun), 32'sd1);
        tready = 1'b1;
        step(1);
        check_val("t3_gap", 32'(axis.TVALID), 32'sd0);
        wait_valid("t3_next");
        check_val("t3_next_data", sin_v, -32'sd2047);
        check_val("t3_next_last", 32'(axis.TLAST), 32'sd1);
        check_val("t3_overrun_sticky", 32'(Overrun), 32'sd1);

        // Enable low with one sample in flight
        tready = 1'b1;
        do_reset();
        wait_valid("t4");
        check_val("t4_s0", sin_v, 32'sd6);
        step(2);
        Enable = 1'b0;
        nvalid = 0; held = 32'sd0;
        for (int k = 0; k < 50; k++) begin
            step(1);
            if (axis.TVALID) begin
                nvalid++;
                held = sin_v;
            end
        end
        check_val("t4_inflight_count", nvalid, 32'sd1);
        check_val("t4_inflight_data", held, 32'sd2047);
        Enable = 1'b1;
        wait_valid("t4_resume");
        check_val("t4_resume_s2", sin_v, -32'sd6);
        step(1);
        wait_valid("t4_resume2");
        check_val("t4_resume_s3", sin_v, -32'sd2047);

        // Reset with a held sample and samples in flight
        tready = 1'b0;
        do_reset();
        step(20);
        check_val("t5_pre_valid", 32'(axis.TVALID), 32'sd1);
        check_val("t5_pre_overrun", 32'(Overrun), 32'sd1);
        Reset = 1'b1;
        step(1);
        check_val("t5_tvalid", 32'(axis.TVALID), 32'sd0);
        check_val("t5_tdata", 32'(axis.TDATA), 32'sd0);
        check_val("t5_tlast", 32'(axis.TLAST), 32'sd0);
        check_val("t5_overrun", 32'(Overrun), 32'sd0);
        Reset = 1'b0;
        tready = 1'b1;
        wait_valid("t5_post");
        check_val("t5_post_s0", sin_v, 32'sd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
